// File: rtl/pid_pkg.sv
// Shared widths, coefficients and helpers for the PID mixer datapath.
package pid_pkg;

  localparam int ERR_W   = 10;
  localparam int D_W     = 13;
  localparam int TERM_W  = 14;
  localparam int INTEG_W = 16;
  localparam int FRWRD_W = 11;
  localparam int MIX_W   = 12;
  localparam int SPD_W   = 11;

  localparam logic signed [TERM_W-1:0] P_COEFF   = 14'sd3;
  localparam logic [FRWRD_W-1:0]       FRWRD_INC = 11'h010;
  localparam logic [FRWRD_W-1:0]       FRWRD_DEC = 11'h020;
  localparam logic [FRWRD_W-1:0]       MAX_FRWRD = 11'h2A0;

  typedef struct packed {
    logic signed [TERM_W-1:0] p;
    logic signed [TERM_W-1:0] i;
    logic signed [TERM_W-1:0] d;
  } stage1_t;

  // Clamp a 12-bit mix result into the signed 11-bit wheel speed range.
  function automatic logic signed [SPD_W-1:0] sat_spd(input logic signed [MIX_W-1:0] v);
    if (!v[MIX_W-1] && v[MIX_W-2])
      return 11'sh3FF;
    else if (v[MIX_W-1] && !v[MIX_W-2])
      return 11'sh400;
    else
      return v[SPD_W-1:0];
  endfunction

endpackage

// File: rtl/iterm_integrator.sv
// Integral accumulator with overflow hold; cleared whenever the robot is not moving.
module iterm_integrator
  import pid_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     err_vld,
  input  logic                     moving,
  input  logic signed [ERR_W-1:0]  err_sat,
  output logic signed [TERM_W-1:0] i_term
);

  logic signed [INTEG_W-1:0] integ_q, integ_d;
  logic signed [INTEG_W-1:0] addend;
  logic signed [INTEG_W-1:0] sum;
  logic                      ovf;

  always_comb begin
    addend  = INTEG_W'(err_sat);
    sum     = integ_q + addend;
    ovf     = (addend[INTEG_W-1] == integ_q[INTEG_W-1]) &&
              (sum[INTEG_W-1] != integ_q[INTEG_W-1]);
    integ_d = integ_q;
    if (!moving)
      integ_d = '0;
    else if (err_vld && !ovf)
      integ_d = sum;
  end

  // The mixer captures the I term of the value being written this edge.
  assign i_term = TERM_W'(integ_d >>> 4);

  always_ff @(posedge clk) begin
    if (rst)
      integ_q <= '0;
    else
      integ_q <= integ_d;
  end

endmodule

// File: rtl/pid_mixer.sv
// Two-stage PID sum and differential wheel mixer with a forward-speed ramp.
module pid_mixer
  import pid_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ERR_W-1:0] err_sat,
  input  logic                    err_vld,
  input  logic signed [D_W-1:0]   D_term,
  input  logic                    moving,
  output logic signed [SPD_W-1:0] lft_spd,
  output logic signed [SPD_W-1:0] rght_spd,
  output logic                    spd_vld
);

  logic signed [TERM_W-1:0]  err_ext;
  logic signed [TERM_W-1:0]  p_term;
  logic signed [TERM_W-1:0]  i_term;

  logic [FRWRD_W-1:0]        frwrd_q, frwrd_d;
  stage1_t                   stg1_q, stg1_d;
  logic                      valid1_q, valid1_d;
  logic signed [SPD_W-1:0]   lft_spd_q, lft_spd_d;
  logic signed [SPD_W-1:0]   rght_spd_q, rght_spd_d;
  logic                      spd_vld_q, spd_vld_d;

  logic signed [TERM_W-1:0]  pid;
  logic signed [MIX_W-1:0]   pid_s;
  logic signed [MIX_W-1:0]   frwrd_mix;
  logic signed [MIX_W-1:0]   lft_mix;
  logic signed [MIX_W-1:0]   rght_mix;

  iterm_integrator u_iterm (
    .clk     (clk),
    .rst     (rst),
    .err_vld (err_vld),
    .moving  (moving),
    .err_sat (err_sat),
    .i_term  (i_term)
  );

  always_comb begin
    err_ext = TERM_W'(err_sat);
    p_term  = err_ext * P_COEFF;
  end

  // Ramp saturates at MAX_FRWRD going up and at zero going down.
  always_comb begin
    frwrd_d = frwrd_q;
    if (err_vld) begin
      if (moving)
        frwrd_d = (frwrd_q >= MAX_FRWRD - FRWRD_INC) ? MAX_FRWRD : frwrd_q + FRWRD_INC;
      else
        frwrd_d = (frwrd_q > FRWRD_DEC) ? frwrd_q - FRWRD_DEC : '0;
    end
  end

  always_comb begin
    stg1_d   = stg1_q;
    valid1_d = err_vld;
    if (err_vld) begin
      stg1_d.p = p_term;
      stg1_d.i = i_term;
      stg1_d.d = TERM_W'(D_term);
    end
  end

  always_comb begin
    pid        = stg1_q.p + stg1_q.i + stg1_q.d;
    pid_s      = MIX_W'(pid >>> 3);
    frwrd_mix  = $signed({1'b0, frwrd_q});
    lft_mix    = frwrd_mix + pid_s;
    rght_mix   = frwrd_mix - pid_s;
    lft_spd_d  = lft_spd_q;
    rght_spd_d = rght_spd_q;
    spd_vld_d  = valid1_q;
    if (valid1_q) begin
      lft_spd_d  = moving ? sat_spd(lft_mix)  : '0;
      rght_spd_d = moving ? sat_spd(rght_mix) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frwrd_q    <= '0;
      stg1_q     <= '0;
      valid1_q   <= 1'b0;
      lft_spd_q  <= '0;
      rght_spd_q <= '0;
      spd_vld_q  <= 1'b0;
    end else begin
      frwrd_q    <= frwrd_d;
      stg1_q     <= stg1_d;
      valid1_q   <= valid1_d;
      lft_spd_q  <= lft_spd_d;
      rght_spd_q <= rght_spd_d;
      spd_vld_q  <= spd_vld_d;
    end
  end

  assign lft_spd  = lft_spd_q;
  assign rght_spd = rght_spd_q;
  assign spd_vld  = spd_vld_q;

endmodule

// File: doc/pid_mixer.md
PID_MIXER -- requirements
Module: pid_mixer

Interface
REQ-001 SHALL have ports, clock and reset first: clk input 1 system clock; rst input 1 reset (one clock; reset is synchronous and active-high).
REQ-002 SHALL have input err_sat, signed 10 bits: saturated heading error.
REQ-003 SHALL have input err_vld, 1 bit: err_sat and D_term are valid this cycle.
REQ-004 SHALL have input D_term, signed 13 bits: derivative term from the upstream D-term stage, valid with err_vld.
REQ-005 SHALL have input moving, 1 bit: the robot is commanded to move.
REQ-006 SHALL have outputs lft_spd and rght_spd, signed 11 bits each: registered wheel speed commands.
REQ-007 SHALL have output spd_vld, 1 bit: one-cycle pulse when lft_spd and rght_spd update.

Function
REQ-008 SHALL compute P_term = err_sat * P_COEFF (P_COEFF = 3), signed 14 bits.
REQ-009 SHALL, on err_vld && moving, add sign-extended err_sat to a signed 16-bit integrator.
REQ-010 SHALL hold the integrator unchanged when the addend and integrator signs match but the sum sign differs (overflow).
REQ-011 SHALL clear the integrator to 0 on any clock edge where moving = 0.
REQ-012 SHALL define I_term = integrator >>> 4, sign-extended to 14 bits.
REQ-013 SHALL keep frwrd as an 11-bit unsigned ramp register that updates only on err_vld.
REQ-014 SHALL, when moving = 1, add FRWRD_INC (0x10) to frwrd, clamped at MAX_FRWRD (0x2A0); when moving = 0, subtract FRWRD_DEC (0x20), floored at 0 (never wraps).
REQ-015 SHALL form a stage-1 pipeline register set: on err_vld, capture P_term, I_term input and sign-extended D_term; the integrator and frwrd update on the same edge; valid1 is set to err_vld.
REQ-016 SHALL compute in stage 2, when valid1 = 1: PID = P + I + D (14-bit signed, no overflow possible) and PID_s = PID >>> 3.
REQ-017 SHALL compute lft = frwrd + PID_s and rght = frwrd - PID_s at 12 bits, then saturate each to the signed 11-bit range [-1024, 1023].
REQ-018 SHALL register lft_spd and rght_spd on valid1, and pulse spd_vld for one cycle; an err_vld at edge N SHALL produce spd_vld high during cycle N+2.
REQ-019 SHALL drive lft_spd = rght_spd = 0 on the stage-2 update if moving = 0 at that edge.
REQ-020 SHALL hold lft_spd and rght_spd between updates.
REQ-021 SHALL accept back-to-back err_vld every cycle, with one spd_vld per err_vld.

Reset
REQ-022 SHALL, when rst = 1 at a clock edge, zero the integrator, frwrd, all stage registers, valid1, lft_spd, rght_spd and spd_vld.
REQ-023 SHALL drop any in-flight valid on reset mid-operation, with no spd_vld afterwards for pre-reset samples.
REQ-024 SHALL give rst priority over err_vld on the same edge.

Structure
REQ-025 SHALL place P_COEFF, FRWRD_INC, FRWRD_DEC, MAX_FRWRD and the term widths in shared package pid_pkg.
REQ-026 SHALL implement the integrator and its overflow guard (REQ-009..REQ-012) as sub-module iterm_integrator.
REQ-027 SHALL keep the frwrd ramp and mixing logic in pid_mixer.

Verification
REQ-028 SHALL cover reset: rst = 1 for one edge mid-stream -> all outputs 0, spd_vld 0 until a new err_vld plus 2 cycles.
REQ-029 SHALL cover latency: moving = 1, frwrd = 0, single err_vld with err_sat = 0, D_term = 0 -> spd_vld in cycle N+2, lft_spd = rght_spd = 0x010.
REQ-030 SHALL cover the P and I path: moving = 1 from reset, one err_vld with err_sat = +80, D_term = 0 -> PID = 245, PID_s = 30, lft_spd = 46, rght_spd = -14.
REQ-031 SHALL cover the integrator guard: err_sat = +511 for 70 err_vld -> integrator 32704 after 64 pulses, then held; I_term = 2044.
REQ-032 SHALL cover saturation: after 42 pulses (frwrd = 0x2A0), err_sat = +511, D_term = +889 -> lft_spd = 0x3FF, rght_spd = frwrd - PID_s, not saturated.
REQ-033 SHALL cover stopping: moving 1->0 with frwrd = 0x050 -> integrator 0 on the next edge; frwrd goes 0x030, 0x010, 0x000, 0x000 over four err_vld; outputs 0.
